// File: rtl/sample_width_convert_pkg.sv
// Shared format definitions for the sample width converter: mode bit
// positions, the mode encoding and the channel-tag width helper.
package sample_fmt_pkg;

    localparam int MODE_SIGNED_BIT  = 0;
    localparam int MODE_JUSTIFY_BIT = 1;

    typedef enum logic [1:0] {
        FMT_U_LSB = 2'd0,
        FMT_S_LSB = 2'd1,
        FMT_U_MSB = 2'd2,
        FMT_S_MSB = 2'd3
    } fmt_mode_e;

    // Channel tag width; a single-channel stream still carries a 1-bit tag.
    function automatic int ch_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/sample_width_convert_if.sv
// Stream bundle for the sample width converter: input beat, output beat,
// clip sideband and clip-counter access. The converter is the slave.
interface sample_width_convert_if #(
    parameter int IN_WD  = 16,
    parameter int OUT_WD = 24,
    parameter int CH_NUM = 2,
    parameter int CNT_WD = 16
);
    localparam int CH_WD = sample_fmt_pkg::ch_width(CH_NUM);

    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [IN_WD-1:0]           in_data_i;
    logic [CH_WD-1:0]           in_ch_i;
    logic [1:0]                 mode_i;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [OUT_WD-1:0]          out_data_o;
    logic [CH_WD-1:0]           out_ch_o;
    logic                       clip_o;
    logic [CH_NUM*CNT_WD-1:0]   clip_cnt_o;
    logic                       clip_clr_i;

    modport master (
        output in_valid_i, in_data_i, in_ch_i, mode_i, out_ready_i, clip_clr_i,
        input  in_ready_o, out_valid_o, out_data_o, out_ch_o, clip_o, clip_cnt_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_ch_i, mode_i, out_ready_i, clip_clr_i,
        output in_ready_o, out_valid_o, out_data_o, out_ch_o, clip_o, clip_cnt_o
    );

endinterface

// File: rtl/sample_width_convert_round_sat.sv
// Combinational stage-2 conversion: extend/justify when widening, pass
// through on equal widths, clamp (optionally after rounding) when narrowing.
module sample_round_sat
    import sample_fmt_pkg::*;
#(
    parameter int IN_WD  = 16,
    parameter int OUT_WD = 24
) (
    input  logic [IN_WD-1:0]  data_i,
    input  logic [IN_WD:0]    rsum_i,
    input  logic [1:0]        mode_i,
    output logic [OUT_WD-1:0] data_o,
    output logic              clip_o
);

    if (OUT_WD > IN_WD) begin : g_widen
        localparam int PAD = OUT_WD - IN_WD;
        logic unused_s;
        assign unused_s = ^rsum_i;

        // Widening never clips: justify shifts up, otherwise extend the MSBs.
        always_comb begin
            clip_o = 1'b0;
            if (mode_i[MODE_JUSTIFY_BIT]) begin
                data_o = {data_i, {PAD{1'b0}}};
            end else if (mode_i[MODE_SIGNED_BIT]) begin
                data_o = {{PAD{data_i[IN_WD-1]}}, data_i};
            end else begin
                data_o = {{PAD{1'b0}}, data_i};
            end
        end
    end else if (OUT_WD == IN_WD) begin : g_pass
        logic unused_s;
        assign unused_s = ^{rsum_i, mode_i};
        assign data_o   = data_i;
        assign clip_o   = 1'b0;
    end else begin : g_narrow
        localparam int D = IN_WD - OUT_WD;
        // Two guard bits above the data keep unsigned rounding overflow positive.
        localparam logic signed [IN_WD+1:0] S_MAX = {{(D+3){1'b0}}, {(OUT_WD-1){1'b1}}};
        localparam logic signed [IN_WD+1:0] S_MIN = ~S_MAX;
        localparam logic signed [IN_WD+1:0] U_MAX = {{(D+2){1'b0}}, {OUT_WD{1'b1}}};

        logic signed [IN_WD+1:0] val_s;

        // Form the pre-clamp value, then clamp it to the output range.
        always_comb begin
            if (mode_i[MODE_JUSTIFY_BIT]) begin
                if (mode_i[MODE_SIGNED_BIT]) begin
                    val_s = $signed({rsum_i[IN_WD], rsum_i}) >>> D;
                end else begin
                    val_s = $signed({1'b0, rsum_i}) >>> D;
                end
            end else if (mode_i[MODE_SIGNED_BIT]) begin
                val_s = $signed({{2{data_i[IN_WD-1]}}, data_i});
            end else begin
                val_s = $signed({2'b00, data_i});
            end

            data_o = val_s[OUT_WD-1:0];
            clip_o = 1'b0;
            if (mode_i[MODE_SIGNED_BIT]) begin
                if (val_s > S_MAX) begin
                    data_o = S_MAX[OUT_WD-1:0];
                    clip_o = 1'b1;
                end else if (val_s < S_MIN) begin
                    data_o = S_MIN[OUT_WD-1:0];
                    clip_o = 1'b1;
                end else begin
                    data_o = val_s[OUT_WD-1:0];
                    clip_o = 1'b0;
                end
            end else begin
                if (val_s > U_MAX) begin
                    data_o = U_MAX[OUT_WD-1:0];
                    clip_o = 1'b1;
                end else begin
                    data_o = val_s[OUT_WD-1:0];
                    clip_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sample_width_convert.sv
// Two-stage valid/ready sample width converter with per-channel saturating
// clip counters. Stage 1 captures the beat (and its rounding sum), stage 2
// holds the converted, registered output.
module sample_width_convert
    import sample_fmt_pkg::*;
#(
    parameter int IN_WD  = 16,
    parameter int OUT_WD = 24,
    parameter int CH_NUM = 2,
    parameter int CNT_WD = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    sample_width_convert_if.slave bus
);

    localparam int CH_WD = ch_width(CH_NUM);
    localparam int RND_D = (IN_WD > OUT_WD) ? (IN_WD - OUT_WD) : 1;
    localparam logic [IN_WD:0]    RND_HALF = {{IN_WD{1'b0}}, 1'b1} << (RND_D - 1);
    localparam logic [CNT_WD-1:0] CNT_ONE  = {{(CNT_WD-1){1'b0}}, 1'b1};
    localparam logic [CNT_WD-1:0] CNT_MAX  = {CNT_WD{1'b1}};

    logic                s1_valid_r;
    logic [IN_WD-1:0]    s1_data_r;
    logic [CH_WD-1:0]    s1_ch_r;
    fmt_mode_e           s1_mode_r;
    logic [IN_WD:0]      s1_rsum_r;
    logic                s2_valid_r;
    logic [OUT_WD-1:0]   s2_data_r;
    logic [CH_WD-1:0]    s2_ch_r;
    logic                s2_clip_r;

    logic                s1_adv_s;
    logic                s2_adv_s;
    logic [IN_WD:0]      in_ext_s;
    logic [IN_WD:0]      rsum_s;
    logic [OUT_WD-1:0]   conv_data_s;
    logic                conv_clip_s;
    logic                clip_hit_s;

    assign s2_adv_s       = ~s2_valid_r | bus.out_ready_i;
    assign s1_adv_s       = ~s1_valid_r | s2_adv_s;
    assign bus.in_ready_o = s1_adv_s;

    assign in_ext_s = bus.mode_i[MODE_SIGNED_BIT] ? {bus.in_data_i[IN_WD-1], bus.in_data_i}
                                                  : {1'b0, bus.in_data_i};
    assign rsum_s   = in_ext_s + RND_HALF;

    // Stage 1: capture the accepted beat, its mode and its round-half-up sum.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {IN_WD{1'b0}};
            s1_ch_r    <= {CH_WD{1'b0}};
            s1_mode_r  <= FMT_U_LSB;
            s1_rsum_r  <= {(IN_WD+1){1'b0}};
        end else if (s1_adv_s) begin
            s1_valid_r <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_data_r <= bus.in_data_i;
                s1_ch_r   <= bus.in_ch_i;
                s1_mode_r <= fmt_mode_e'(bus.mode_i);
                s1_rsum_r <= rsum_s;
            end
        end
    end

    sample_round_sat #(
        .IN_WD  (IN_WD),
        .OUT_WD (OUT_WD)
    ) u_round_sat (
        .data_i (s1_data_r),
        .rsum_i (s1_rsum_r),
        .mode_i (s1_mode_r),
        .data_o (conv_data_s),
        .clip_o (conv_clip_s)
    );

    // Stage 2: register the converted sample whenever the output slot frees up.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= {OUT_WD{1'b0}};
            s2_ch_r    <= {CH_WD{1'b0}};
            s2_clip_r  <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_data_r <= conv_data_s;
                s2_ch_r   <= s1_ch_r;
                s2_clip_r <= conv_clip_s;
            end
        end
    end

    assign bus.out_valid_o = s2_valid_r;
    assign bus.out_data_o  = s2_data_r;
    assign bus.out_ch_o    = s2_ch_r;
    assign bus.clip_o      = s2_clip_r;

    assign clip_hit_s = s2_valid_r & bus.out_ready_i & s2_clip_r;

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_cnt
        logic [CNT_WD-1:0] cnt_r;
        logic              hit_s;

        assign hit_s = clip_hit_s & (s2_ch_r == CH_WD'(gi));

        // Saturating clip count; a clear still records a clip landing the same cycle.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_r <= {CNT_WD{1'b0}};
            end else if (bus.clip_clr_i) begin
                cnt_r <= hit_s ? CNT_ONE : {CNT_WD{1'b0}};
            end else if (hit_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end

        assign bus.clip_cnt_o[gi*CNT_WD +: CNT_WD] = cnt_r;
    end

endmodule

// File: tb/tb_sample_width_convert.sv
// Bench for sample_width_convert: a 16->24 widening instance and a 24->16
// narrowing instance (4-bit clip counters), each scoreboarded against an
// integer reference model, plus directed scenario checks.
module tb_sample_width_convert;
    import sample_fmt_pkg::*;

    typedef struct {
        logic [23:0] data;
        logic        ch;
        bit          clip;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q_w[$];
    exp_t q_n[$];

    bit          hold_w, hold_n;
    logic [23:0] hd_w, hd_n;
    logic        hc_w, hc_n, hk_w, hk_n;

    always #5 clk = ~clk;

    sample_width_convert_if #(.IN_WD(16), .OUT_WD(24), .CH_NUM(2), .CNT_WD(16)) bw();
    sample_width_convert_if #(.IN_WD(24), .OUT_WD(16), .CH_NUM(2), .CNT_WD(4))  bn();

    sample_width_convert #(.IN_WD(16), .OUT_WD(24), .CH_NUM(2), .CNT_WD(16)) u_wide (
        .clk_i (clk), .rst_i (rst), .bus (bw)
    );
    sample_width_convert #(.IN_WD(24), .OUT_WD(16), .CH_NUM(2), .CNT_WD(4)) u_narrow (
        .clk_i (clk), .rst_i (rst), .bus (bn)
    );

    // Integer reference: interpret, round, clamp, then mask to the output width.
    function automatic void ref_conv(input int iw, input int ow, input logic [23:0] d,
                                     input logic [1:0] m, output logic [23:0] o, output bit c);
        longint v, lo, hi, r;
        bit     sg, js;
        sg = m[0];
        js = m[1];
        v  = longint'(d) & ((64'sd1 <<< iw) - 64'sd1);
        if (sg && (((v >>> (iw - 1)) & 64'sd1) == 64'sd1)) v = v - (64'sd1 <<< iw);
        c = 1'b0;
        if (ow > iw) begin
            r = js ? ((longint'(d) & ((64'sd1 <<< iw) - 64'sd1)) <<< (ow - iw)) : v;
        end else if (ow == iw) begin
            r = v;
        end else begin
            if (js) v = (v + (64'sd1 <<< (iw - ow - 1))) >>> (iw - ow);
            lo = sg ? -(64'sd1 <<< (ow - 1)) : 64'sd0;
            hi = sg ? ((64'sd1 <<< (ow - 1)) - 64'sd1) : ((64'sd1 <<< ow) - 64'sd1);
            if (v > hi) begin
                v = hi; c = 1'b1;
            end else if (v < lo) begin
                v = lo; c = 1'b1;
            end
            r = v;
        end
        o = 24'(r & ((64'sd1 <<< ow) - 64'sd1));
    endfunction

    // Scoreboard and output-stability monitor for the widening instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q_w.delete();
            hold_w = 1'b0;
        end else begin
            if (hold_w) begin
                n_vec++;
                if (bw.out_valid_o !== 1'b1 || bw.out_data_o !== hd_w || bw.out_ch_o !== hc_w || bw.clip_o !== hk_w) begin
                    n_err++;
                    $display("FAIL stable_w: got v=%b d=%h ch=%b clip=%b, required v=1 d=%h ch=%b clip=%b",
                             bw.out_valid_o, bw.out_data_o, bw.out_ch_o, bw.clip_o, hd_w, hc_w, hk_w);
                end
            end
            hold_w = bw.out_valid_o && !bw.out_ready_i;
            hd_w = bw.out_data_o; hc_w = bw.out_ch_o; hk_w = bw.clip_o;
            if (bw.out_valid_o && bw.out_ready_i) begin
                n_vec++;
                if (q_w.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_w: got unexpected beat d=%h, required none", bw.out_data_o);
                end else begin
                    e = q_w.pop_front();
                    if (bw.out_data_o !== e.data || bw.out_ch_o !== e.ch || bw.clip_o !== e.clip) begin
                        n_err++;
                        $display("FAIL sb_w: got d=%h ch=%b clip=%b, required d=%h ch=%b clip=%b",
                                 bw.out_data_o, bw.out_ch_o, bw.clip_o, e.data, e.ch, e.clip);
                    end
                end
            end
            if (bw.in_valid_i && bw.in_ready_o) begin
                ref_conv(16, 24, {8'd0, bw.in_data_i}, bw.mode_i, e.data, e.clip);
                e.ch = bw.in_ch_i;
                q_w.push_back(e);
            end
        end
    end

    // Scoreboard and output-stability monitor for the narrowing instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q_n.delete();
            hold_n = 1'b0;
        end else begin
            if (hold_n) begin
                n_vec++;
                if (bn.out_valid_o !== 1'b1 || {8'd0, bn.out_data_o} !== hd_n || bn.out_ch_o !== hc_n || bn.clip_o !== hk_n) begin
                    n_err++;
                    $display("FAIL stable_n: got v=%b d=%h ch=%b clip=%b, required v=1 d=%h ch=%b clip=%b",
                             bn.out_valid_o, bn.out_data_o, bn.out_ch_o, bn.clip_o, hd_n, hc_n, hk_n);
                end
            end
            hold_n = bn.out_valid_o && !bn.out_ready_i;
            hd_n = {8'd0, bn.out_data_o}; hc_n = bn.out_ch_o; hk_n = bn.clip_o;
            if (bn.out_valid_o && bn.out_ready_i) begin
                n_vec++;
                if (q_n.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_n: got unexpected beat d=%h, required none", bn.out_data_o);
                end else begin
                    e = q_n.pop_front();
                    if ({8'd0, bn.out_data_o} !== e.data || bn.out_ch_o !== e.ch || bn.clip_o !== e.clip) begin
                        n_err++;
                        $display("FAIL sb_n: got d=%h ch=%b clip=%b, required d=%h ch=%b clip=%b",
                                 bn.out_data_o, bn.out_ch_o, bn.clip_o, e.data, e.ch, e.clip);
                    end
                end
            end
            if (bn.in_valid_i && bn.in_ready_o) begin
                ref_conv(24, 16, bn.in_data_i, bn.mode_i, e.data, e.clip);
                e.ch = bn.in_ch_i;
                q_n.push_back(e);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_w(input bit v, input logic [15:0] d, input logic ch, input logic [1:0] m, input bit rdy);
        bw.in_valid_i  = v;
        bw.in_data_i   = d;
        bw.in_ch_i     = ch;
        bw.mode_i      = m;
        bw.out_ready_i = rdy;
        bw.clip_clr_i  = 1'b0;
    endtask

    task automatic drive_n(input bit v, input logic [23:0] d, input logic ch, input logic [1:0] m,
                           input bit rdy, input bit clr);
        bn.in_valid_i  = v;
        bn.in_data_i   = d;
        bn.in_ch_i     = ch;
        bn.mode_i      = m;
        bn.out_ready_i = rdy;
        bn.clip_clr_i  = clr;
    endtask

    task automatic test_reset;
        drive_w(1'b0, 16'h0000, 1'b0, FMT_U_LSB, 1'b1);
        drive_n(1'b0, 24'h000000, 1'b0, FMT_U_LSB, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (3) tick();
        n_vec++; if (bw.out_valid_o !== 1'b0 || bw.clip_o !== 1'b0 || bw.out_ch_o !== 1'b0) begin n_err++; $display("FAIL reset_ctl_w: got v=%b clip=%b ch=%b, required 0 0 0", bw.out_valid_o, bw.clip_o, bw.out_ch_o); end
        n_vec++; if (bw.out_data_o !== 24'h000000 || bw.clip_cnt_o !== 32'h0) begin n_err++; $display("FAIL reset_data_w: got d=%h cnt=%h, required 0 0", bw.out_data_o, bw.clip_cnt_o); end
        n_vec++; if (bw.in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready_w: got %b, required 1", bw.in_ready_o); end
        n_vec++; if (bn.out_valid_o !== 1'b0 || bn.clip_o !== 1'b0 || bn.out_ch_o !== 1'b0) begin n_err++; $display("FAIL reset_ctl_n: got v=%b clip=%b ch=%b, required 0 0 0", bn.out_valid_o, bn.clip_o, bn.out_ch_o); end
        n_vec++; if (bn.out_data_o !== 16'h0000 || bn.clip_cnt_o !== 8'h00) begin n_err++; $display("FAIL reset_data_n: got d=%h cnt=%h, required 0 0", bn.out_data_o, bn.clip_cnt_o); end
        n_vec++; if (bn.in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready_n: got %b, required 1", bn.in_ready_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_widen;
        logic [1:0]  mode_tab[4] = '{FMT_S_LSB, FMT_U_LSB, FMT_S_MSB, FMT_U_MSB};
        logic [23:0] exp_tab[4]  = '{24'hFF8001, 24'h008001, 24'h800100, 24'h800100};
        for (int i = 0; i < 4; i++) begin
            drive_w(1'b1, 16'h8001, 1'(i), mode_tab[i], 1'b1);
            tick();
            drive_w(1'b0, 16'h0000, 1'b0, FMT_U_LSB, 1'b1);
            n_vec++; if (bw.out_valid_o !== 1'b0) begin n_err++; $display("FAIL widen_lat1 %0d: got valid %b, required 0", i, bw.out_valid_o); end
            tick();
            n_vec++; if (bw.out_valid_o !== 1'b1 || bw.out_data_o !== exp_tab[i] || bw.clip_o !== 1'b0) begin n_err++; $display("FAIL widen %0d: got v=%b d=%h clip=%b, required v=1 d=%h clip=0", i, bw.out_valid_o, bw.out_data_o, bw.clip_o, exp_tab[i]); end
            tick();
        end
    endtask

    task automatic test_narrow;
        logic [23:0] din[8]  = '{24'h123480, 24'h7FFF80, 24'h800000, 24'h123456, 24'hFF8000, 24'hFF7FFF, 24'hFFFF80, 24'h00017F};
        logic [1:0]  md[8]   = '{FMT_S_MSB, FMT_S_MSB, FMT_S_MSB, FMT_U_LSB, FMT_S_LSB, FMT_S_LSB, FMT_U_MSB, FMT_U_MSB};
        logic [15:0] dout[8] = '{16'h1235, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF, 16'h0001};
        logic        clp[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive_n(1'b1, din[i], 1'b0, md[i], 1'b1, 1'b0);
            tick();
            drive_n(1'b0, 24'h000000, 1'b0, FMT_U_LSB, 1'b1, 1'b0);
            n_vec++; if (bn.out_valid_o !== 1'b0) begin n_err++; $display("FAIL narrow_lat1 %0d: got valid %b, required 0", i, bn.out_valid_o); end
            tick();
            n_vec++; if (bn.out_valid_o !== 1'b1 || bn.out_data_o !== dout[i] || bn.clip_o !== clp[i]) begin n_err++; $display("FAIL narrow %0d: got v=%b d=%h clip=%b, required v=1 d=%h clip=%b", i, bn.out_valid_o, bn.out_data_o, bn.clip_o, dout[i], clp[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure;
        logic [23:0] beats[3] = '{24'h000011, 24'h000022, 24'h000033};
        int idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive_n(1'b1, beats[(idx < 3) ? idx : 2], 1'b0, FMT_S_LSB, 1'b0, 1'b0);
            #1;
            if (bn.in_ready_o) idx++;
            tick();
        end
        n_vec++; if (idx !== 2) begin n_err++; $display("FAIL bp_accepted: got %0d beats, required 2", idx); end
        n_vec++; if (bn.in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b, required 0", bn.in_ready_o); end
        for (int k = 0; k < 3; k++) begin
            drive_n(idx < 3, beats[(idx < 3) ? idx : 2], 1'b0, FMT_S_LSB, 1'b1, 1'b0);
            #1;
            n_vec++; if (bn.out_valid_o !== 1'b1 || bn.out_data_o !== beats[k][15:0]) begin n_err++; $display("FAIL bp_order %0d: got v=%b d=%h, required v=1 d=%h", k, bn.out_valid_o, bn.out_data_o, beats[k][15:0]); end
            if (bn.in_valid_i && bn.in_ready_o) idx++;
            tick();
        end
        drive_n(1'b0, 24'h000000, 1'b0, FMT_U_LSB, 1'b1, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_clip_counters;
        drive_n(1'b0, 24'h000000, 1'b0, FMT_U_LSB, 1'b1, 1'b1);
        tick();
        drive_n(1'b0, 24'h000000, 1'b0, FMT_U_LSB, 1'b1, 1'b0);
        n_vec++; if (bn.clip_cnt_o !== 8'h00) begin n_err++; $display("FAIL cnt_clear: got %h, required 00", bn.clip_cnt_o); end
        for (int i = 0; i < 20; i++) begin
            drive_n(1'b1, 24'h7FFFFF, 1'b1, FMT_S_LSB, 1'b1, 1'b0);
            tick();
        end
        drive_n(1'b0, 24'h000000, 1'b0, FMT_U_LSB, 1'b1, 1'b0);
        repeat (3) tick();
        n_vec++; if (bn.clip_cnt_o !== 8'hF0) begin n_err++; $display("FAIL cnt_sat: got %h, required f0", bn.clip_cnt_o); end
        for (int i = 0; i < 3; i++) begin
            drive_n(1'b1, 24'h800000, 1'b0, FMT_U_LSB, 1'b1, 1'b0);
            tick();
        end
        drive_n(1'b0, 24'h000000, 1'b0, FMT_U_LSB, 1'b1, 1'b0);
        repeat (3) tick();
        n_vec++; if (bn.clip_cnt_o !== 8'hF3) begin n_err++; $display("FAIL cnt_ch0: got %h, required f3", bn.clip_cnt_o); end
        drive_n(1'b1, 24'h7FFFFF, 1'b1, FMT_S_LSB, 1'b1, 1'b0);
        tick();
        drive_n(1'b0, 24'h000000, 1'b0, FMT_U_LSB, 1'b1, 1'b0);
        tick();
        drive_n(1'b0, 24'h000000, 1'b0, FMT_U_LSB, 1'b1, 1'b1);
        n_vec++; if (bn.out_valid_o !== 1'b1 || bn.clip_o !== 1'b1 || bn.out_ch_o !== 1'b1) begin n_err++; $display("FAIL cnt_setup: got v=%b clip=%b ch=%b, required 1 1 1", bn.out_valid_o, bn.clip_o, bn.out_ch_o); end
        tick();
        drive_n(1'b0, 24'h000000, 1'b0, FMT_U_LSB, 1'b1, 1'b0);
        n_vec++; if (bn.clip_cnt_o !== 8'h10) begin n_err++; $display("FAIL cnt_clr_hit: got %h, required 10", bn.clip_cnt_o); end
        tick();
    endtask

    task automatic test_reset_inflight;
        drive_w(1'b1, 16'h1234, 1'b0, FMT_S_LSB, 1'b0);
        tick();
        drive_w(1'b1, 16'h5678, 1'b1, FMT_S_LSB, 1'b0);
        tick();
        drive_w(1'b0, 16'h0000, 1'b0, FMT_U_LSB, 1'b0);
        n_vec++; if (bw.out_valid_o !== 1'b1 || bw.in_ready_o !== 1'b0) begin n_err++; $display("FAIL inflight_setup: got v=%b rdy=%b, required 1 0", bw.out_valid_o, bw.in_ready_o); end
        rst = 1'b1;
        #1;
        n_vec++; if (bw.out_valid_o !== 1'b0 || bw.in_ready_o !== 1'b1) begin n_err++; $display("FAIL async_reset: got v=%b rdy=%b, required 0 1", bw.out_valid_o, bw.in_ready_o); end
        tick();
        tick();
        rst = 1'b0;
        drive_w(1'b0, 16'h0000, 1'b0, FMT_U_LSB, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bw.out_valid_o !== 1'b0) begin n_err++; $display("FAIL stale_beat %0d: got valid %b, required 0", i, bw.out_valid_o); end
        end
        drive_w(1'b1, 16'h00AB, 1'b0, FMT_U_LSB, 1'b1);
        tick();
        drive_w(1'b0, 16'h0000, 1'b0, FMT_U_LSB, 1'b1);
        n_vec++; if (bw.out_valid_o !== 1'b0) begin n_err++; $display("FAIL post_reset_lat1: got valid %b, required 0", bw.out_valid_o); end
        tick();
        n_vec++; if (bw.out_valid_o !== 1'b1 || bw.out_data_o !== 24'h0000AB) begin n_err++; $display("FAIL post_reset_beat: got v=%b d=%h, required v=1 d=0000ab", bw.out_valid_o, bw.out_data_o); end
        tick();
    endtask

    task automatic test_random;
        int          acc = 0;
        int          cyc = 0;
        logic [23:0] d;
        bit          v;
        while (acc < 10000 && cyc < 40000) begin
            case ($urandom_range(0, 3))
                0:       d = 24'h7FFF00 | 24'($urandom_range(0, 255));
                1:       d = 24'h800000 | 24'($urandom_range(0, 255));
                2:       d = 24'hFFFF00 | 24'($urandom_range(0, 255));
                default: d = 24'($urandom);
            endcase
            v = ($urandom_range(0, 9) < 7);
            drive_n(v, d, 1'($urandom), 2'($urandom), $urandom_range(0, 9) < 7, 1'b0);
            #1;
            if (v && bn.in_ready_o) acc++;
            tick();
            cyc++;
        end
        n_vec++; if (acc < 10000) begin n_err++; $display("FAIL stress_n_budget: got %0d beats, required 10000", acc); end
        acc = 0;
        cyc = 0;
        while (acc < 3000 && cyc < 12000) begin
            v = ($urandom_range(0, 9) < 7);
            drive_w(v, 16'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 9) < 7);
            #1;
            if (v && bw.in_ready_o) acc++;
            tick();
            cyc++;
        end
        n_vec++; if (acc < 3000) begin n_err++; $display("FAIL stress_w_budget: got %0d beats, required 3000", acc); end
        drive_n(1'b0, 24'h000000, 1'b0, FMT_U_LSB, 1'b1, 1'b0);
        drive_w(1'b0, 16'h0000, 1'b0, FMT_U_LSB, 1'b1);
        repeat (6) tick();
        n_vec++; if (q_n.size() != 0 || q_w.size() != 0) begin n_err++; $display("FAIL drain: got %0d/%0d beats outstanding, required 0/0", q_n.size(), q_w.size()); end
    endtask

    initial begin
        test_reset();
        test_widen();
        test_narrow();
        test_backpressure();
        test_clip_counters();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sample_width_convert.md
Name: sample_width_convert

Overview:
- Streaming, multi-channel audio sample width converter for the codec datapath, between sample sources (tone generator, filters) and the serialiser.
- Widens or narrows samples per beat under a runtime mode:
  - sign or zero extension, or MSB-justify when widening;
  - round-half-up with saturation when narrowing.
- Two-stage registered pipeline with valid/ready handshake, plus per-channel saturating clip counters for level monitoring.

Parameters:
- IN_WD, 16, input sample width (>=2)
- OUT_WD, 24, output sample width (>=2; may be <, =, > IN_WD)
- CH_NUM, 2, number of channels tagged on the stream (>=1)
- CNT_WD, 16, width of each clip counter
- Derived constant: CH_WD = max(1, $clog2(CH_NUM))

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  block can accept a beat
- in_data_i  in  IN_WD  input sample
- in_ch_i  in  CH_WD  channel tag of input sample
- mode_i  in  2  bit0 = signed, bit1 = MSB-justify; sampled per accepted beat
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accepts beat
- out_data_o  out  OUT_WD  converted sample
- out_ch_o  out  CH_WD  channel tag, travels with the sample
- clip_o  out  1  sideband: this output beat was saturated
- clip_cnt_o  out  CH_NUM*CNT_WD  packed per-channel clip counts, channel 0 in LSBs
- clip_clr_i  in  1  synchronous clear of all clip counters

Behaviour:
- Reset:
  - out_valid_o=0, out_data_o=0, out_ch_o=0, clip_o=0, clip_cnt_o=0; both stage-valid flags 0.
  - in_ready_o=1 once the pipeline is empty.
  - Reset mid-operation discards in-flight beats; no partial output.
- Handshake:
  - Transfer occurs when valid & ready are both high.
  - out_valid_o and all output data/sideband stay stable until out_ready_i is high.
  - Stage 2 advances when !s2_valid | out_ready_i. Stage 1 advances when !s1_valid | s2_adv.
  - in_ready_o = s1_adv. The combinational path out_ready_i -> in_ready_o is permitted.
- Latency and throughput:
  - Exactly 2 cycles from input transfer to out_valid_o.
  - One beat per cycle sustained while out_ready_i=1.
  - Maximum 2 beats in flight; beat order preserved; no drops or duplicates.
- Stage 1: registers data, channel and mode. For narrowing with justify=1, it also registers the rounded sum in_data + 2^(D-1), computed IN_WD+1 bits wide, where D = IN_WD-OUT_WD.
- Stage 2: applies the per-mode conversion below, then registers out_data, out_ch and the clip flag.
- Widening (OUT_WD>IN_WD), never clips:
  - justify=0: extend MSBs, sign-extending when signed=1 and zero-extending otherwise.
  - justify=1: data << (OUT_WD-IN_WD), LSBs zero; signedness irrelevant.
- Equal widths: pass-through, clip=0.
- Narrowing, justify=1: rounded sum >> D, then clamp.
  - signed: clamp to [-2^(OUT_WD-1), 2^(OUT_WD-1)-1]
  - unsigned: clamp to [0, 2^OUT_WD-1]
- Narrowing, justify=0: no rounding; clamp the IN_WD value to the OUT_WD range (same clamp rule as justify=1).
- Clip flag: clip=1 whenever a clamp altered the value.
- Clip counters:
  - Counter[out_ch] increments on each output transfer with clip_o=1.
  - Saturates at 2^CNT_WD-1; no wrap.
  - Tags >= CH_NUM pass data unchanged but count nothing.
- Clear vs count: clip_clr_i clears all counters.
  - Clear and a clipped transfer in the same cycle: that channel = 1, all others = 0.

Decomposition:
- Package sample_fmt_pkg holds:
  - MODE_SIGNED_BIT=0 and MODE_JUSTIFY_BIT=1 constants;
  - mode typedef enum logic[1:0] {FMT_U_LSB, FMT_S_LSB, FMT_U_MSB, FMT_S_MSB}.
- One combinational sub-module, sample_round_sat, implements the stage-2 conversion and clip flag, parametrised by IN_WD/OUT_WD. It is unit-testable standalone.
- The top module holds the pipeline registers, handshake and counters.

Test Plan:
- IN_WD=16, OUT_WD=24, in=0x8001 -> FMT_S_LSB gives 0xFF8001; FMT_U_LSB gives 0x008001; FMT_S_MSB gives 0x800100. out_valid_o rises exactly 2 cycles after each transfer; clip_o=0.
- IN_WD=24, OUT_WD=16, FMT_S_MSB -> 0x123480 gives 0x1235; 0x7FFF80 gives 0x7FFF with clip_o=1; 0x800000 gives 0x8000 with clip_o=0.
- Backpressure: out_ready_i=0 for 6 cycles while offering beats A,B,C -> only A,B accepted and in_ready_o=0. After release: A,B,C delivered in order, one per cycle.
- Clip counters, CNT_WD=4, ch1 receives 20 clipped beats -> clip_cnt_o ch1=15, ch0=0. Then assert clip_clr_i coincident with a ch1 clip -> ch1=1.
- Reset asserted with 2 beats in flight -> out_valid_o=0 immediately (async); after release no stale beat appears and the first new beat has 2-cycle latency.
- Random mode/data/ready stress against a reference model -> zero mismatches over 10k beats; handshake stability assertion never fires.
